// File: rtl/tm1638_pkg.sv
// TM1638 responder shared definitions: command fields, mode codes,
// FSM states and the key-byte selector.
package tm1638_pkg;

    localparam logic [1:0] CMD_DATA = 2'b01;
    localparam logic [1:0] CMD_CTRL = 2'b10;
    localparam logic [1:0] CMD_ADDR = 2'b11;

    localparam logic [1:0] DATA_WRITE = 2'b00;
    localparam logic [1:0] DATA_READ  = 2'b10;

    localparam logic MODE_WRITE = 1'b0;
    localparam logic MODE_READ  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_RDATA,
        ST_DROP
    } state_t;

    function automatic logic [7:0] key_byte(
        input logic [31:0] keys,
        input logic [1:0]  idx
    );
        return keys[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/tm1638_sync_edge.sv
// N-flop input synchronizer with rise/fall pulses on the synced level.
// RST_VAL matches the line's idle level so reset never fakes an edge.
module tm1638_sync_edge #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [N-1:0] sync;
    logic         prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= {N{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sync <= {sync[N-2:0], d};
            prev <= sync[N-1];
        end
    end

    assign q    = sync[N-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/tm1638_responder.sv
// Device-side TM1638 link: LSB-first command/data receiver, 16x8 display
// RAM, display control and key-scan readback.
module tm1638_responder
    import tm1638_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int RAM_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_clk,
    input  logic        spi_cs_n,
    input  logic        spi_di,
    output logic        spi_do,
    output logic        spi_oe,
    input  logic [31:0] key_data,
    input  logic [3:0]  disp_addr,
    output logic [7:0]  disp_data,
    output logic        disp_on,
    output logic [2:0]  brightness,
    output logic        wr_strobe,
    output logic [3:0]  wr_addr,
    output logic        cmd_err
);

    logic clk_q, clk_rise, clk_fall;
    logic cs_q, cs_rise, cs_fall;
    logic di_q, di_rise, di_fall;

    tm1638_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clk (
        .clk(clk), .reset_n(reset_n), .d(spi_clk),
        .q(clk_q), .rise(clk_rise), .fall(clk_fall)
    );

    tm1638_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset_n(reset_n), .d(spi_cs_n),
        .q(cs_q), .rise(cs_rise), .fall(cs_fall)
    );

    tm1638_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_di (
        .clk(clk), .reset_n(reset_n), .d(spi_di),
        .q(di_q), .rise(di_rise), .fall(di_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{clk_q, di_rise, di_fall};

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt;
    logic [6:0]  shreg;
    logic [7:0]  byte_q;
    logic        byte_vld;
    logic        act;
    logic        cmd_bad;
    logic [3:0]  addr;
    logic        mode;
    logic        fixed;
    logic [1:0]  key_idx;
    logic [7:0]  key_sh;
    logic [7:0]  ram [RAM_DEPTH];

    assign disp_data = ram[disp_addr];
    assign act       = byte_vld & ~cs_rise;

    always_comb begin
        state_d = state_q;
        cmd_bad = 1'b0;
        if (cs_rise) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (cs_fall) state_d = ST_CMD;
                ST_CMD: begin
                    if (byte_vld) begin
                        state_d = ST_DROP;
                        case (byte_q[7:6])
                            CMD_DATA: begin
                                if (byte_q[1:0] == DATA_READ)
                                    state_d = ST_RDATA;
                                else if (byte_q[1:0] != DATA_WRITE)
                                    cmd_bad = 1'b1;
                            end
                            CMD_ADDR: begin
                                if (mode == MODE_WRITE)
                                    state_d = ST_WDATA;
                            end
                            CMD_CTRL: ;
                            default: cmd_bad = 1'b1;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // A completed byte is registered here and acted on one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt  <= '0;
            shreg    <= '0;
            byte_q   <= '0;
            byte_vld <= 1'b0;
        end else begin
            byte_vld <= 1'b0;
            if (cs_rise || cs_fall) begin
                bit_cnt <= '0;
            end else if (clk_rise && !cs_q) begin
                shreg   <= {di_q, shreg[6:1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_q   <= {di_q, shreg};
                    byte_vld <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spi_do     <= 1'b0;
            spi_oe     <= 1'b0;
            disp_on    <= 1'b0;
            brightness <= '0;
            wr_strobe  <= 1'b0;
            wr_addr    <= '0;
            cmd_err    <= 1'b0;
            addr       <= '0;
            mode       <= MODE_WRITE;
            fixed      <= 1'b0;
            key_idx    <= '0;
            key_sh     <= '0;
            for (int i = 0; i < RAM_DEPTH; i++) ram[i] <= 8'h00;
        end else begin
            wr_strobe <= 1'b0;
            cmd_err   <= cmd_bad;
            if (cs_rise) begin
                spi_oe <= 1'b0;
                spi_do <= 1'b0;
            end else if (clk_fall && spi_oe) begin
                spi_do <= key_sh[0];
                key_sh <= {1'b0, key_sh[7:1]};
            end
            if (act) begin
                case (state_q)
                    ST_CMD: begin
                        case (byte_q[7:6])
                            CMD_DATA: begin
                                if (!cmd_bad) begin
                                    mode  <= (byte_q[1:0] == DATA_READ) ?
                                             MODE_READ : MODE_WRITE;
                                    fixed <= byte_q[2];
                                end
                                if (state_d == ST_RDATA) begin
                                    spi_oe  <= 1'b1;
                                    key_sh  <= key_byte(key_data, 2'd0);
                                    key_idx <= 2'd1;
                                end
                            end
                            CMD_ADDR: addr <= byte_q[3:0];
                            CMD_CTRL: begin
                                disp_on    <= byte_q[3];
                                brightness <= byte_q[2:0];
                            end
                            default: ;
                        endcase
                    end
                    ST_WDATA: begin
                        ram[addr] <= byte_q;
                        wr_strobe <= 1'b1;
                        wr_addr   <= addr;
                        if (!fixed) addr <= addr + 4'd1;
                    end
                    ST_RDATA: begin
                        key_sh  <= key_byte(key_data, key_idx);
                        key_idx <= key_idx + 2'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tm1638_responder.sv
// Directed bench for tm1638_responder: a bus master model drives frames
// and each scenario task compares outputs with hand-computed values.
module tb_tm1638_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        spi_clk;
    logic        spi_cs_n;
    logic        spi_di;
    logic        spi_do;
    logic        spi_oe;
    logic [31:0] key_data;
    logic [3:0]  disp_addr;
    logic [7:0]  disp_data;
    logic        disp_on;
    logic [2:0]  brightness;
    logic        wr_strobe;
    logic [3:0]  wr_addr;
    logic        cmd_err;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int err_cnt  = 0;
    logic [3:0] wr_q[$];
    logic oe_seen;

    tm1638_responder dut (
        .clk(clk), .reset_n(reset_n),
        .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_di(spi_di),
        .spi_do(spi_do), .spi_oe(spi_oe), .key_data(key_data),
        .disp_addr(disp_addr), .disp_data(disp_data),
        .disp_on(disp_on), .brightness(brightness),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) begin
            wr_cnt++;
            wr_q.push_back(wr_addr);
        end
        if (cmd_err) err_cnt++;
    end

    task automatic clear_mon();
        wr_cnt  = 0;
        err_cnt = 0;
        wr_q.delete();
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            spi_clk = 1'b0;
            spi_di  = b[i];
            #80;
            oe_seen = oe_seen | spi_oe;
            spi_clk = 1'b1;
            #80;
        end
    endtask

    task automatic spi_read(output logic [7:0] r, output logic oe_all,
                            input int chg_bit, input logic [31:0] chg_val);
        oe_all = 1'b1;
        for (int i = 0; i < 8; i++) begin
            spi_clk = 1'b0;
            spi_di  = 1'b0;
            if (i == chg_bit) key_data = chg_val;
            #80;
            r[i]   = spi_do;
            oe_all = oe_all & spi_oe;
            spi_clk = 1'b1;
            #80;
        end
    endtask

    task automatic frame_start();
        spi_cs_n = 1'b0;
        #100;
    endtask

    task automatic frame_end();
        #60;
        spi_cs_n = 1'b1;
        #100;
    endtask

    task automatic send1(input logic [7:0] b);
        frame_start();
        spi_byte(b);
        frame_end();
    endtask

    task automatic test_reset();
        logic [7:0] d;
        n_checks++;
        if (spi_oe !== 1'b0) begin
            n_fail++; $display("FAIL reset_oe: got %b want 0", spi_oe);
        end
        n_checks++;
        if (spi_do !== 1'b0) begin
            n_fail++; $display("FAIL reset_do: got %b want 0", spi_do);
        end
        n_checks++;
        if (disp_on !== 1'b0) begin
            n_fail++; $display("FAIL reset_disp_on: got %b want 0", disp_on);
        end
        n_checks++;
        if (brightness !== 3'd0) begin
            n_fail++; $display("FAIL reset_bright: got %0d want 0", brightness);
        end
        n_checks++;
        if (wr_strobe !== 1'b0 || wr_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_wr: got %b/%0d want 0/0", wr_strobe, wr_addr);
        end
        n_checks++;
        if (cmd_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_cmd_err: got %b want 0", cmd_err);
        end
        for (int i = 0; i < 16; i += 5) begin
            disp_addr = 4'(i);
            #10;
            d = disp_data;
            n_checks++;
            if (d !== 8'h00) begin
                n_fail++; $display("FAIL reset_ram[%0d]: got %h want 00", i, d);
            end
        end
    endtask

    task automatic test_write_auto();
        clear_mon();
        send1(8'h40);
        frame_start();
        spi_byte(8'hC0);
        for (int i = 1; i <= 16; i++) spi_byte(8'(i));
        frame_end();
        n_checks++;
        if (wr_cnt !== 16) begin
            n_fail++; $display("FAIL auto_wr_count: got %0d want 16", wr_cnt);
        end
        for (int i = 0; i < 16; i++) begin
            disp_addr = 4'(i);
            #10;
            n_checks++;
            if (disp_data !== 8'(i + 1)) begin
                n_fail++;
                $display("FAIL auto_ram[%0d]: got %h want %h", i, disp_data, 8'(i + 1));
            end
            n_checks++;
            if (i >= wr_q.size() || wr_q[i] !== 4'(i)) begin
                n_fail++;
                $display("FAIL auto_wr_addr[%0d]: got %0d want %0d", i,
                         (i < wr_q.size()) ? wr_q[i] : 4'hx, i);
            end
        end
    endtask

    task automatic test_wrap();
        clear_mon();
        frame_start();
        spi_byte(8'hCF);
        spi_byte(8'h77);
        spi_byte(8'h78);
        frame_end();
        n_checks++;
        if (wr_q.size() != 2 || wr_q[0] !== 4'd15 || wr_q[1] !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap_addrs: got %0d writes, want 15 then 0", wr_q.size());
        end
        disp_addr = 4'd15;
        #10;
        n_checks++;
        if (disp_data !== 8'h77) begin
            n_fail++; $display("FAIL wrap_ram15: got %h want 77", disp_data);
        end
        disp_addr = 4'd0;
        #10;
        n_checks++;
        if (disp_data !== 8'h78) begin
            n_fail++; $display("FAIL wrap_ram0: got %h want 78", disp_data);
        end
    endtask

    task automatic test_fixed();
        clear_mon();
        send1(8'h44);
        frame_start();
        spi_byte(8'hC5);
        spi_byte(8'hAA);
        spi_byte(8'h55);
        frame_end();
        n_checks++;
        if (wr_q.size() != 2 || wr_q[0] !== 4'd5 || wr_q[1] !== 4'd5) begin
            n_fail++;
            $display("FAIL fixed_addrs: got %0d writes, want 5 twice", wr_q.size());
        end
        disp_addr = 4'd5;
        #10;
        n_checks++;
        if (disp_data !== 8'h55) begin
            n_fail++; $display("FAIL fixed_ram5: got %h want 55", disp_data);
        end
        disp_addr = 4'd6;
        #10;
        n_checks++;
        if (disp_data !== 8'h07) begin
            n_fail++; $display("FAIL fixed_ram6: got %h want 07", disp_data);
        end
    endtask

    task automatic test_ctrl();
        send1(8'h8B);
        n_checks++;
        if (disp_on !== 1'b1 || brightness !== 3'd3) begin
            n_fail++;
            $display("FAIL ctrl_on: got %b/%0d want 1/3", disp_on, brightness);
        end
        send1(8'h80);
        n_checks++;
        if (disp_on !== 1'b0 || brightness !== 3'd0) begin
            n_fail++;
            $display("FAIL ctrl_off: got %b/%0d want 0/0", disp_on, brightness);
        end
    endtask

    task automatic test_read();
        logic [7:0] r;
        logic       oe_all;
        logic [7:0] exp_b [5];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
        exp_b[3] = 8'h44; exp_b[4] = 8'h11;
        key_data = 32'h4433_2211;
        oe_seen  = 1'b0;
        frame_start();
        spi_byte(8'h42);
        n_checks++;
        if (oe_seen !== 1'b0) begin
            n_fail++; $display("FAIL read_oe_cmd: got %b want 0", oe_seen);
        end
        for (int k = 0; k < 5; k++) begin
            // K1 is overwritten mid-byte; the captured copy must survive.
            spi_read(r, oe_all, (k == 1) ? 4 : -1, 32'h4433_0011);
            n_checks++;
            if (r !== exp_b[k]) begin
                n_fail++; $display("FAIL read_byte%0d: got %h want %h", k, r, exp_b[k]);
            end
            n_checks++;
            if (oe_all !== 1'b1) begin
                n_fail++; $display("FAIL read_oe%0d: got %b want 1", k, oe_all);
            end
        end
        frame_end();
        n_checks++;
        if (spi_oe !== 1'b0) begin
            n_fail++; $display("FAIL read_oe_end: got %b want 0", spi_oe);
        end
        key_data = 32'h4433_2211;
        clear_mon();
        frame_start();
        spi_byte(8'hC2);
        spi_byte(8'h99);
        frame_end();
        disp_addr = 4'd2;
        #10;
        n_checks++;
        if (wr_cnt !== 0 || disp_data !== 8'h03) begin
            n_fail++;
            $display("FAIL read_mode_addr: got %0d writes ram2=%h want 0/03", wr_cnt, disp_data);
        end
    endtask

    task automatic test_abort();
        logic [7:0] b;
        b = 8'hF0;
        send1(8'h40);
        clear_mon();
        frame_start();
        spi_byte(8'hC3);
        for (int i = 0; i < 4; i++) begin
            spi_clk = 1'b0; spi_di = b[i]; #80;
            spi_clk = 1'b1; #80;
        end
        frame_end();
        disp_addr = 4'd3;
        #10;
        n_checks++;
        if (wr_cnt !== 0) begin
            n_fail++; $display("FAIL abort_wr: got %0d want 0", wr_cnt);
        end
        n_checks++;
        if (disp_data !== 8'h04) begin
            n_fail++; $display("FAIL abort_ram3: got %h want 04", disp_data);
        end
        n_checks++;
        if (spi_oe !== 1'b0) begin
            n_fail++; $display("FAIL abort_oe: got %b want 0", spi_oe);
        end
    endtask

    task automatic test_cmd_err();
        clear_mon();
        send1(8'h00);
        n_checks++;
        if (err_cnt !== 1) begin
            n_fail++; $display("FAIL err_00: got %0d want 1", err_cnt);
        end
        send1(8'h41);
        n_checks++;
        if (err_cnt !== 2) begin
            n_fail++; $display("FAIL err_41: got %0d want 2", err_cnt);
        end
        send1(8'h8F);
        n_checks++;
        if (err_cnt !== 2) begin
            n_fail++; $display("FAIL err_legal: got %0d want 2", err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'hAB;
        n_checks++;
        if (disp_on !== 1'b1 || brightness !== 3'd7) begin
            n_fail++;
            $display("FAIL mid_pre: got %b/%0d want 1/7", disp_on, brightness);
        end
        frame_start();
        spi_byte(8'hC1);
        for (int i = 0; i < 4; i++) begin
            spi_clk = 1'b0; spi_di = b[i]; #80;
            spi_clk = 1'b1; #80;
        end
        reset_n = 1'b0;
        #20;
        n_checks++;
        if (disp_on !== 1'b0 || brightness !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_ctrl: got %b/%0d want 0/0", disp_on, brightness);
        end
        n_checks++;
        if (spi_oe !== 1'b0 || spi_do !== 1'b0 || wr_strobe !== 1'b0 ||
            wr_addr !== 4'd0 || cmd_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_outs: got oe=%b do=%b ws=%b wa=%0d ce=%b want zeros",
                     spi_oe, spi_do, wr_strobe, wr_addr, cmd_err);
        end
        for (int i = 1; i < 16; i += 4) begin
            disp_addr = 4'(i);
            #10;
            n_checks++;
            if (disp_data !== 8'h00) begin
                n_fail++; $display("FAIL mid_ram[%0d]: got %h want 00", i, disp_data);
            end
        end
        spi_cs_n = 1'b1;
        spi_clk  = 1'b1;
        #20;
        reset_n = 1'b1;
        #50;
    endtask

    initial begin
        reset_n   = 1'b0;
        spi_clk   = 1'b1;
        spi_cs_n  = 1'b1;
        spi_di    = 1'b0;
        key_data  = '0;
        disp_addr = '0;
        oe_seen   = 1'b0;
        #23;
        reset_n = 1'b1;
        #20;
        test_reset();
        test_write_auto();
        test_wrap();
        test_fixed();
        test_ctrl();
        test_read();
        test_abort();
        test_cmd_err();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
